// File: rtl/ram_fifo_ctrl.sv
// Stream-to-RAM FIFO controller: sequences writes and read-backs on one shared
// single-port RAM and registers the read word onto a valid/ready output stream.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  dbg_state
);

  // Handshakes: a word moves on s_* (or m_*) exactly at a posedge where valid
  // and ready are both high; valid never waits on ready.
  localparam logic IDLE    = 1'b0;
  localparam logic RD_WAIT = 1'b1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  rd_go, wr_en;

  always_comb begin
    rd_go    = (state_q == IDLE) && !m_valid_q && (count_q != '0);
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    // Reads own the port whenever the output register needs refilling.
    s_ready  = rst && !clr && !rd_go && !full;
    wr_en    = s_valid && s_ready;
    ram_we   = wr_en;
    ram_addr = rd_go ? rd_ptr_q : wr_ptr_q;
    ram_din  = s_data;
  end

  always_comb begin
    state_d   = (state_q == IDLE && rd_go) ? RD_WAIT : IDLE;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + CNT_ONE;
    end
    if (rd_go) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end
    if (state_q == RD_WAIT) begin
      m_valid_d = 1'b1;
      m_data_d  = ram_dout;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    // Flush drops everything, including a word arriving from an in-flight read.
    if (clr) begin
      state_d   = IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      m_valid_d = 1'b0;
      m_data_d  = m_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl driving a behavioural single-port RAM.
module tb_ram_fifo_ctrl;

  logic       clk, rst, clr;
  logic       s_valid, s_ready;
  logic [7:0] s_data;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [4:0] count;
  logic       full, empty, dbg_state;

  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .count(count), .full(full), .empty(empty), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sync_ram: registered read, write-enable on the same port
  logic [7:0] mem [16];
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // pointer-wrap monitor, sampled at the active edge before state updates
  logic       saw_wr_wrap, saw_rd_wrap;
  logic [3:0] last_wr_addr, last_rd_addr, prev_addr;
  initial begin
    saw_wr_wrap = 0; saw_rd_wrap = 0;
    last_wr_addr = 0; last_rd_addr = 0; prev_addr = 0;
  end
  always @(posedge clk) begin
    if (rst) begin
      if (ram_we) begin
        if (last_wr_addr == 4'hF && ram_addr == 4'h0) saw_wr_wrap = 1;
        last_wr_addr = ram_addr;
      end
      if (dbg_state == 1'b1) begin
        if (last_rd_addr == 4'hF && prev_addr == 4'h0) saw_rd_wrap = 1;
        last_rd_addr = prev_addr;
      end
      prev_addr = ram_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at a negedge with s_valid still high
  task automatic push(input logic [7:0] d);
    bit ok;
    int n;
    s_valid = 1; s_data = d; ok = 0; n = 0;
    while (!ok && n < 100) begin
      #1; ok = s_ready;
      @(posedge clk); @(negedge clk);
      n++;
    end
    if (ok) exp_q.push_back(d);
    else check_eq("push_timeout", 0, 1);
  endtask

  task automatic drain(input int n_words, input int budget);
    int got, cyc;
    got = 0; cyc = 0;
    m_ready = 1;
    while (got < n_words && cyc < budget) begin
      if (m_valid) begin
        check_eq("drain_data", m_data, exp_q.pop_front());
        got++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    m_ready = 0;
    check_eq("drain_count", got, n_words);
  endtask

  initial begin
    int n;
    rst = 0; clr = 0; s_valid = 0; s_data = 0; m_ready = 0;

    // 1: reset
    repeat (3) @(negedge clk);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_m_valid", m_valid, 0);
    rst = 1;
    @(negedge clk);
    check_eq("rel_m_valid", m_valid, 0);
    check_eq("rel_count", count, 0);
    check_eq("rel_empty", empty, 1);
    check_eq("rel_full", full, 0);
    check_eq("rel_ram_we", ram_we, 0);
    check_eq("rel_s_ready", s_ready, 1);
    check_eq("rel_m_data", m_data, 0);

    // 2: ordering with output held
    push(8'hA0); push(8'h40); push(8'hE0); push(8'h80);
    s_valid = 0;
    check_eq("ord_m_valid", m_valid, 1);
    check_eq("ord_m_data", m_data, 8'hA0);
    check_eq("ord_count", count, 3);
    @(posedge clk); @(negedge clk);
    check_eq("ord_hold", m_data, 8'hA0);
    drain(4, 40);
    repeat (3) @(negedge clk);
    check_eq("ord_empty", empty, 1);
    check_eq("ord_m_valid_end", m_valid, 0);

    // 3: fill to capacity
    n = 0;
    s_valid = 1;
    for (int i = 0; i < 30; i++) begin
      s_data = n[7:0];
      #1;
      if (s_ready) begin
        exp_q.push_back(n[7:0]);
        n++;
      end
      @(posedge clk); @(negedge clk);
    end
    s_valid = 0;
    check_eq("full_accepted", n, 17);
    check_eq("full_flag", full, 1);
    check_eq("full_count", count, 16);
    #1;
    check_eq("full_s_ready", s_ready, 0);
    drain(17, 200);
    repeat (3) @(negedge clk);
    check_eq("full_drained", empty, 1);

    // 4: wrap with random output stalls
    saw_wr_wrap = 0; saw_rd_wrap = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) push(8'((i * 7 + 3) & 8'hFF));
        s_valid = 0;
      end
      begin
        int got, cyc;
        got = 0; cyc = 0;
        while (got < 40 && cyc < 3000) begin
          m_ready = 1'($urandom_range(0, 1));
          #1;
          if (m_valid && m_ready) begin
            check_eq("wrap_data", m_data, exp_q.pop_front());
            got++;
          end
          @(posedge clk); @(negedge clk);
          cyc++;
        end
        m_ready = 0;
        check_eq("wrap_count", got, 40);
      end
    join
    check_eq("wrap_wr_ptr", saw_wr_wrap, 1);
    check_eq("wrap_rd_ptr", saw_rd_wrap, 1);
    check_eq("wrap_q_empty", exp_q.size(), 0);

    // 5: flush during RD_WAIT
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    s_valid = 0;
    exp_q.delete();
    check_eq("flush_pre_count", count, 4);
    m_ready = 1;
    @(posedge clk); @(negedge clk);
    m_ready = 0;
    @(posedge clk); @(negedge clk);
    check_eq("flush_in_rd_wait", dbg_state, 1);
    clr = 1;
    #1;
    check_eq("flush_s_ready", s_ready, 0);
    check_eq("flush_ram_we", ram_we, 0);
    @(posedge clk); @(negedge clk);
    clr = 0;
    check_eq("flush_count", count, 0);
    check_eq("flush_m_valid", m_valid, 0);
    check_eq("flush_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    check_eq("flush_no_ghost", m_valid, 0);
    push(8'h5A);
    s_valid = 0;
    drain(1, 20);

    // 6: async reset mid-drain
    push(8'h11); push(8'h22); push(8'h33);
    s_valid = 0;
    check_eq("arst_pre_valid", m_valid, 1);
    check_eq("arst_pre_count", count, 2);
    m_ready = 1;
    @(posedge clk);
    #2 rst = 0;
    #1;
    check_eq("arst_m_valid", m_valid, 0);
    check_eq("arst_count", count, 0);
    check_eq("arst_empty", empty, 1);
    check_eq("arst_s_ready", s_ready, 0);
    check_eq("arst_ram_we", ram_we, 0);
    @(negedge clk);
    rst = 1; m_ready = 0;
    exp_q.delete();
    @(negedge clk);
    check_eq("arst_rel_count", count, 0);
    check_eq("arst_rel_s_ready", s_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
